ni_flit_injector: RTL and testbench

// Transmit-side counterpart of the router input_port. Accepts packet descriptors plus a payload stream from the local

---
 rtl/ni_flit_injector.sv | 117 +++++++++++
 tb/tb_ni_flit_injector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ni_flit_injector.sv
// Network-interface transmit side: segments packet descriptors plus a payload stream into
// HEAD/BODY/TAIL/HEADTAIL flits and injects them on a round-robin chosen downstream VC.
module ni_flit_injector #(
  parameter int PKT_SIZE_W        = 4,
  parameter int VC_NUM            = 2,
  parameter int DEST_ADDR_SIZE_X  = 2,
  parameter int DEST_ADDR_SIZE_Y  = 2,
  parameter int HEAD_PAYLOAD_SIZE = 12,
  localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int FLIT_DATA_SIZE   = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE,
  localparam int FLIT_W           = 2 + VC_SIZE + FLIT_DATA_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid_i,
  output logic                         pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic [PKT_SIZE_W-1:0]        pkt_size_i,
  input  logic                         pl_valid_i,
  output logic                         pl_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
  input  logic [VC_NUM-1:0]            is_on_off_i,
  input  logic [VC_NUM-1:0]            is_allocatable_vc_i,
  output logic [FLIT_W-1:0]            data_o,
  output logic                         valid_flit_o,
  output logic                         busy_o
);

  // state  | meaning
  // IDLE   | waiting for a descriptor and an eligible VC; emits HEAD/HEADTAIL on accept
  // STREAM | emitting BODY/TAIL flits on cur_vc as payload words arrive

  // data_o layout: {label[1:0], vc_id, data}; data is {x, y, head_pl} for heads, bt_pl otherwise
  localparam logic [1:0] LBL_HEAD     = 2'b00;
  localparam logic [1:0] LBL_BODY     = 2'b01;
  localparam logic [1:0] LBL_TAIL     = 2'b10;
  localparam logic [1:0] LBL_HEADTAIL = 2'b11;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  logic [VC_SIZE-1:0]  last_vc;
  logic [VC_SIZE-1:0]  cur_vc;
  logic [PKT_SIZE_W-1:0] rem;

  logic [VC_NUM-1:0]   elig;
  logic [VC_SIZE-1:0]  sel_vc;
  logic [VC_SIZE:0]    cand;
  logic                single_flit;
  logic                last_word;

  assign elig        = is_allocatable_vc_i & is_on_off_i;
  assign single_flit = (pkt_size_i <= PKT_SIZE_W'(1));
  assign last_word   = (rem == PKT_SIZE_W'(1));

  assign pkt_ready_o = ~rst & (state == IDLE) & pkt_valid_i & (|elig);
  assign pl_ready_o  = ~rst & (state == STREAM) & pl_valid_i & is_on_off_i[cur_vc];
  assign busy_o      = (state != IDLE);

  // Scan from farthest to nearest so the first eligible VC after last_vc wins.
  always_comb begin
    sel_vc = '0;
    cand   = '0;
    for (int i = VC_NUM; i >= 1; i--) begin
      cand = {1'b0, last_vc} + (VC_SIZE+1)'(i);
      if (cand >= (VC_SIZE+1)'(VC_NUM))
        cand = cand - (VC_SIZE+1)'(VC_NUM);
      if (elig[cand[VC_SIZE-1:0]])
        sel_vc = cand[VC_SIZE-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      valid_flit_o <= 1'b0;
      data_o       <= '0;
      last_vc      <= '0;
      cur_vc       <= '0;
      rem          <= '0;
    end else begin
      valid_flit_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_ready_o) begin
            cur_vc       <= sel_vc;
            last_vc      <= sel_vc;
            valid_flit_o <= 1'b1;
            data_o       <= {(single_flit ? LBL_HEADTAIL : LBL_HEAD), sel_vc,
                             pkt_x_dest_i, pkt_y_dest_i, pkt_head_pl_i};
            if (single_flit) begin
              rem   <= '0;
              state <= IDLE;
            end else begin
              rem   <= pkt_size_i - PKT_SIZE_W'(1);
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          // no consume leaves a bubble: data_o, rem and state hold
          if (pl_ready_o) begin
            valid_flit_o <= 1'b1;
            data_o       <= {(last_word ? LBL_TAIL : LBL_BODY), cur_vc, pl_data_i};
            rem          <= rem - PKT_SIZE_W'(1);
            if (last_word)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench for ni_flit_injector: packet segmentation, round-robin VC choice,
// flow-control stalls and asynchronous reset mid-packet.
module tb_ni_flit_injector;

  localparam int FLIT_W = 19;
  localparam logic [1:0] L_HEAD     = 2'b00;
  localparam logic [1:0] L_BODY     = 2'b01;
  localparam logic [1:0] L_TAIL     = 2'b10;
  localparam logic [1:0] L_HEADTAIL = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid_i, pkt_ready_o;
  logic [1:0]        pkt_x_dest_i, pkt_y_dest_i;
  logic [11:0]       pkt_head_pl_i;
  logic [3:0]        pkt_size_i;
  logic              pl_valid_i, pl_ready_o;
  logic [15:0]       pl_data_i;
  logic [1:0]        is_on_off_i, is_allocatable_vc_i;
  logic [FLIT_W-1:0] data_o;
  logic              valid_flit_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  ni_flit_injector dut (
    .clk                 (clk),
    .rst                 (rst),
    .pkt_valid_i         (pkt_valid_i),
    .pkt_ready_o         (pkt_ready_o),
    .pkt_x_dest_i        (pkt_x_dest_i),
    .pkt_y_dest_i        (pkt_y_dest_i),
    .pkt_head_pl_i       (pkt_head_pl_i),
    .pkt_size_i          (pkt_size_i),
    .pl_valid_i          (pl_valid_i),
    .pl_ready_o          (pl_ready_o),
    .pl_data_i           (pl_data_i),
    .is_on_off_i         (is_on_off_i),
    .is_allocatable_vc_i (is_allocatable_vc_i),
    .data_o              (data_o),
    .valid_flit_o        (valid_flit_o),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] lbl, input logic vc,
                                                input logic [15:0] d);
    return {lbl, vc, d};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle showing the last flit.
  task automatic send_pkt(input logic [1:0] x, input logic [1:0] y, input logic [11:0] hpl,
                          input logic [3:0] size, input logic [15:0] base, input logic exp_vc);
    int nf;
    nf = (size <= 4'd1) ? 1 : int'(size);
    pkt_x_dest_i  = x;
    pkt_y_dest_i  = y;
    pkt_head_pl_i = hpl;
    pkt_size_i    = size;
    pkt_valid_i   = 1'b1;
    pl_valid_i    = 1'b1;
    pl_data_i     = base;
    #1 check_eq("pkt_ready", 32'(pkt_ready_o), 32'd1);
    @(posedge clk); #1;
    pkt_valid_i = 1'b0;
    check_eq("head_valid", 32'(valid_flit_o), 32'd1);
    check_eq("head_flit", 32'(data_o),
             32'(mk_flit((nf == 1) ? L_HEADTAIL : L_HEAD, exp_vc, {x, y, hpl})));
    check_eq("head_busy", 32'(busy_o), 32'(nf > 1));
    for (int k = 1; k < nf; k++) begin
      @(posedge clk); #1;
      check_eq("bt_valid", 32'(valid_flit_o), 32'd1);
      check_eq("bt_flit", 32'(data_o),
               32'(mk_flit((k == nf-1) ? L_TAIL : L_BODY, exp_vc, base + 16'(k-1))));
      check_eq("bt_busy", 32'(busy_o), 32'(k < nf-1));
      pl_data_i = base + 16'(k);
    end
    pl_valid_i = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FLIT_W-1:0] exp_last;
    int k, cyc;
    logic stall;

    rst = 1'b1;
    pkt_valid_i = 1'b1;
    pkt_x_dest_i = '0; pkt_y_dest_i = '0; pkt_head_pl_i = '0; pkt_size_i = 4'd1;
    pl_valid_i = 1'b1; pl_data_i = '0;
    is_on_off_i = 2'b11; is_allocatable_vc_i = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid_flit_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
    check_eq("rst_pl_ready", 32'(pl_ready_o), 32'd0);
    rst = 1'b0; pkt_valid_i = 1'b0; pl_valid_i = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_valid", 32'(valid_flit_o), 32'd0);

    // 4-flit packet, rr starts after VC0
    send_pkt(2'd1, 2'd2, 12'hABC, 4'd4, 16'h1000, 1'b1);

    // single-flit packets, then size 0 treated as HEADTAIL on the next VC
    send_pkt(2'd2, 2'd1, 12'h123, 4'd1, 16'h2000, 1'b0);
    @(posedge clk); #1;
    check_eq("ht_one_cycle", 32'(valid_flit_o), 32'd0);
    send_pkt(2'd3, 2'd0, 12'h456, 4'd0, 16'h2100, 1'b1);
    @(posedge clk); #1;
    check_eq("ht0_one_cycle", 32'(valid_flit_o), 32'd0);

    // 6-flit packet on VC0 with is_on_off[0] low for stream cycles 2..4
    pkt_x_dest_i = 2'd0; pkt_y_dest_i = 2'd1; pkt_head_pl_i = 12'h777; pkt_size_i = 4'd6;
    pkt_valid_i = 1'b1; pl_valid_i = 1'b1; pl_data_i = 16'h3000;
    #1 check_eq("s_pkt_ready", 32'(pkt_ready_o), 32'd1);
    @(posedge clk); #1;
    pkt_valid_i = 1'b0;
    exp_last = mk_flit(L_HEAD, 1'b0, {2'd0, 2'd1, 12'h777});
    check_eq("s_head", 32'(data_o), 32'(exp_last));
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 20) begin
      cyc++;
      stall = (cyc >= 2 && cyc <= 4);
      is_on_off_i = stall ? 2'b10 : 2'b11;
      if (cyc == 3) pkt_valid_i = 1'b1;
      #1 check_eq("s_pl_ready", 32'(pl_ready_o), 32'(!stall));
      if (cyc == 3) begin
        check_eq("s_pkt_ready_stream", 32'(pkt_ready_o), 32'd0);
        pkt_valid_i = 1'b0;
      end
      @(posedge clk); #1;
      if (stall) begin
        check_eq("s_bubble", 32'(valid_flit_o), 32'd0);
        check_eq("s_hold", 32'(data_o), 32'(exp_last));
        check_eq("s_busy", 32'(busy_o), 32'd1);
      end else begin
        exp_last = mk_flit((k == 4) ? L_TAIL : L_BODY, 1'b0, 16'h3000 + 16'(k));
        check_eq("s_valid", 32'(valid_flit_o), 32'd1);
        check_eq("s_flit", 32'(data_o), 32'(exp_last));
        k++;
        pl_data_i = 16'h3000 + 16'(k);
      end
    end
    check_eq("s_cycles", 32'(cyc), 32'd8);
    check_eq("s_busy_end", 32'(busy_o), 32'd0);
    is_on_off_i = 2'b11; pl_valid_i = 1'b0;

    // nothing allocatable: no accept; then only VC0
    is_allocatable_vc_i = 2'b00;
    pkt_x_dest_i = 2'd0; pkt_y_dest_i = 2'd3; pkt_head_pl_i = 12'h055; pkt_size_i = 4'd1;
    pkt_valid_i = 1'b1;
    #1 check_eq("na_pkt_ready", 32'(pkt_ready_o), 32'd0);
    @(posedge clk); #1;
    check_eq("na_valid", 32'(valid_flit_o), 32'd0);
    check_eq("na_busy", 32'(busy_o), 32'd0);
    is_allocatable_vc_i = 2'b01;
    send_pkt(2'd0, 2'd3, 12'h055, 4'd1, 16'h4000, 1'b0);
    is_allocatable_vc_i = 2'b11;

    // back-to-back packets alternate VC 1,0 with no gap
    send_pkt(2'd1, 2'd1, 12'h0A1, 4'd2, 16'h5000, 1'b1);
    send_pkt(2'd2, 2'd2, 12'h0B2, 4'd3, 16'h5100, 1'b0);
    @(posedge clk); #1;
    check_eq("b2b_idle", 32'(valid_flit_o), 32'd0);

    // reset during a BODY of a 15-flit packet
    pkt_x_dest_i = 2'd3; pkt_y_dest_i = 2'd3; pkt_head_pl_i = 12'hFED; pkt_size_i = 4'd15;
    pkt_valid_i = 1'b1; pl_valid_i = 1'b1; pl_data_i = 16'h6000;
    #1 check_eq("r_pkt_ready", 32'(pkt_ready_o), 32'd1);
    @(posedge clk); #1;
    pkt_valid_i = 1'b0;
    check_eq("r_head", 32'(data_o), 32'(mk_flit(L_HEAD, 1'b1, {2'd3, 2'd3, 12'hFED})));
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check_eq("r_body", 32'(data_o), 32'(mk_flit(L_BODY, 1'b1, 16'h6000 + 16'(j))));
      pl_data_i = 16'h6001 + 16'(j);
    end
    #2 rst = 1'b1;
    pkt_valid_i = 1'b1;
    #1;
    check_eq("r_async_valid", 32'(valid_flit_o), 32'd0);
    check_eq("r_async_data", 32'(data_o), 32'd0);
    check_eq("r_async_busy", 32'(busy_o), 32'd0);
    check_eq("r_async_pl_ready", 32'(pl_ready_o), 32'd0);
    check_eq("r_async_pkt_ready", 32'(pkt_ready_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; pkt_valid_i = 1'b0;
    @(posedge clk); #1;
    check_eq("r_no_stale", 32'(valid_flit_o), 32'd0);
    check_eq("r_idle_busy", 32'(busy_o), 32'd0);
    pl_valid_i = 1'b0;
    send_pkt(2'd2, 2'd0, 12'h321, 4'd2, 16'h7000, 1'b1);
    @(posedge clk); #1;
    check_eq("end_idle", 32'(valid_flit_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
